// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage,
// backed by an internal line-wide memory with a fixed access latency.
module data_cache #(
   parameter int LINE_WORDS  = 4,
   parameter int NUM_SETS    = 16,
   parameter int MEM_LATENCY = 50,
   parameter int MEM_LINES   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        is_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_hit,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int WORD_BITS  = $clog2(LINE_WORDS);
   localparam int IDX_BITS   = $clog2(NUM_SETS);
   localparam int TAG_BITS   = 32 - 2 - WORD_BITS - IDX_BITS;
   localparam int LINE_BITS  = 32 * LINE_WORDS;
   localparam int MEM_BITS   = $clog2(MEM_LINES);
   localparam int CNT_BITS   = $clog2(MEM_LATENCY + 1);
   localparam int ALLOC_LAST = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;

   typedef enum logic [1:0] {IDLE, WB, ALLOC, RESP} state_t;

   // RESP is the last cycle of the line read, so ALLOC is skipped at latency 1
   localparam state_t FILL_START = (MEM_LATENCY > 1) ? ALLOC : RESP;

   state_t state, state_next;
   logic [CNT_BITS-1:0] wait_count;

   logic [LINE_BITS-1:0] line_data [NUM_SETS];
   logic [TAG_BITS-1:0]  line_tag  [NUM_SETS];
   logic [NUM_SETS-1:0]  line_valid;
   logic [NUM_SETS-1:0]  line_dirty;
   logic [LINE_BITS-1:0] mem [MEM_LINES];

   logic                 lat_write;
   logic [WORD_BITS-1:0] lat_word;
   logic [IDX_BITS-1:0]  lat_idx;
   logic [TAG_BITS-1:0]  lat_tag;
   logic [31:0]          lat_wdata;

   logic [WORD_BITS-1:0] in_word;
   logic [IDX_BITS-1:0]  in_idx;
   logic [TAG_BITS-1:0]  in_tag;
   logic [1:0]           unused_addr_bits;
   logic                 lookup_hit;
   logic                 victim_dirty;
   logic                 wait_done;
   logic                 alloc_done;
   logic [MEM_BITS-1:0]  victim_addr;
   logic [MEM_BITS-1:0]  fill_addr;
   logic [LINE_BITS-1:0] fill_line;
   logic [31:0]          fill_word;

   assign in_word          = req_addr[2 +: WORD_BITS];
   assign in_idx           = req_addr[2 + WORD_BITS +: IDX_BITS];
   assign in_tag           = req_addr[31 -: TAG_BITS];
   assign unused_addr_bits = req_addr[1:0];

   assign lookup_hit   = line_valid[in_idx] && (line_tag[in_idx] == in_tag);
   assign victim_dirty = line_valid[in_idx] && line_dirty[in_idx];
   assign wait_done    = (wait_count == CNT_BITS'(MEM_LATENCY - 1));
   assign alloc_done   = (wait_count == CNT_BITS'(ALLOC_LAST));
   assign victim_addr  = MEM_BITS'({line_tag[lat_idx], lat_idx});
   assign fill_addr    = MEM_BITS'({lat_tag, lat_idx});
   assign is_ready     = (state == IDLE);

   // The filled line already carries the store word so RESP writes the set once
   always_comb begin
      fill_line = mem[fill_addr];
      fill_word = mem[fill_addr][lat_word*32 +: 32];
      if (lat_write) begin
         fill_line[lat_word*32 +: 32] = lat_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid && !lookup_hit) state_next = victim_dirty ? WB : FILL_START;
         WB:      if (wait_done) state_next = FILL_START;
         ALLOC:   if (alloc_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (state_next != state)) begin
         wait_count <= '0;
      end else if ((state == WB) || (state == ALLOC)) begin
         wait_count <= wait_count + CNT_BITS'(1);
      end
   end

   // Hits complete in the accept cycle; misses latch the request for RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         line_valid <= '0;
         line_dirty <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_hit   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         lat_write  <= 1'b0;
         lat_word   <= '0;
         lat_idx    <= '0;
         lat_tag    <= '0;
         lat_wdata  <= '0;
         for (int i = 0; i < MEM_LINES; i++) begin
            mem[i] <= '0;
         end
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (lookup_hit) begin
                     if (req_write) begin
                        line_data[in_idx][in_word*32 +: 32] <= req_wdata;
                        line_dirty[in_idx] <= 1'b1;
                     end
                     resp_valid <= 1'b1;
                     resp_hit   <= 1'b1;
                     resp_rdata <= req_write ? 32'd0 : line_data[in_idx][in_word*32 +: 32];
                     hit_count  <= hit_count + 32'd1;
                  end else begin
                     lat_write <= req_write;
                     lat_word  <= in_word;
                     lat_idx   <= in_idx;
                     lat_tag   <= in_tag;
                     lat_wdata <= req_wdata;
                  end
               end
            end
            WB: begin
               if (wait_done) begin
                  mem[victim_addr] <= line_data[lat_idx];
               end
            end
            RESP: begin
               line_data[lat_idx]  <= fill_line;
               line_tag[lat_idx]   <= lat_tag;
               line_valid[lat_idx] <= 1'b1;
               line_dirty[lat_idx] <= lat_write;
               resp_valid <= 1'b1;
               resp_hit   <= 1'b0;
               resp_rdata <= lat_write ? 32'd0 : fill_word;
               miss_count <= miss_count + 32'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed scenarios plus randomized traffic checked
// against a flat word-memory model with per-set tag/valid/dirty bookkeeping.
module tb_data_cache;

   localparam int L = 50;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        is_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_hit;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   data_cache dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .is_ready   (is_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_hit   (resp_hit),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          accept;
      int          due;
      logic [31:0] rdata;
      logic        hit;
      logic [31:0] hits;
      logic [31:0] misses;
   } exp_t;

   exp_t expq[$];

   int checks = 0;
   int fails = 0;
   int cycle = 0;
   int resp_seen = 0;
   bit checking_on = 0;
   bit ready_low_seen = 0;

   logic [31:0] mmem [16384];
   logic        mvalid [16];
   logic [23:0] mtag [16];
   logic        mdirty [16];
   logic [31:0] mhits;
   logic [31:0] mmisses;

   int          t_accept;
   int          last_latency;
   logic [31:0] last_rdata;
   logic        last_hit;
   logic [31:0] last_hits;
   logic [31:0] last_misses;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Every cycle: readiness follows outstanding misses, responses land exactly when due
   always @(negedge clk) begin
      if (checking_on) begin
         bit   busy;
         exp_t e;
         busy = 0;
         foreach (expq[i]) begin
            if ((expq[i].accept <= cycle) && (cycle < expq[i].due)) busy = 1;
         end
         checkOutput("is_ready", {31'd0, is_ready}, {31'd0, !busy});
         if ((expq.size() > 0) && (expq[0].due == cycle)) begin
            e = expq.pop_front();
            resp_seen++;
            checkOutput("resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("resp_rdata", resp_rdata, e.rdata);
            checkOutput("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
            checkOutput("hit_count", hit_count, e.hits);
            checkOutput("miss_count", miss_count, e.misses);
         end else begin
            checkOutput("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
         end
      end
   end

   task automatic clearModel();
      for (int i = 0; i < 16384; i++) mmem[i] = 32'd0;
      for (int i = 0; i < 16; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
         mdirty[i] = 1'b0;
      end
      mhits   = 32'd0;
      mmisses = 32'd0;
      expq.delete();
   endtask

   task automatic doReset();
      checking_on = 0;
      reset = 1'b1;
      req_valid = 1'b0;
      clearModel();
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_is_ready", {31'd0, is_ready}, 32'd1);
      checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
      checkOutput("reset_resp_hit", {31'd0, resp_hit}, 32'd0);
      checkOutput("reset_hit_count", hit_count, 32'd0);
      checkOutput("reset_miss_count", miss_count, 32'd0);
      reset = 1'b0;
      checking_on = 1;
   endtask

   task automatic waitResponse();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && (n < 400));
      if (!resp_valid) begin
         checkOutput("response_timeout", 32'd0, 32'd1);
      end
      #1;
      last_latency = cycle - t_accept;
      last_rdata   = resp_rdata;
      last_hit     = resp_hit;
      last_hits    = hit_count;
      last_misses  = miss_count;
   endtask

   // Present one request, record what the model says it must produce once accepted
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input bit wait_resp);
      int          waited;
      int          idx;
      int          widx;
      logic [23:0] tag;
      bit          hit;
      int          lat;
      exp_t        e;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      waited = 0;
      while (!is_ready && (waited < 400)) begin
         @(negedge clk);
         waited++;
      end
      if (!is_ready) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (waited > 0) ready_low_seen = 1;
      idx  = int'(addr[7:4]);
      tag  = addr[31:8];
      widx = int'(addr[15:2]);
      hit  = mvalid[idx] && (mtag[idx] == tag);
      lat  = hit ? 1 : ((mvalid[idx] && mdirty[idx]) ? 1 + 2 * L : 1 + L);
      if (!hit) begin
         mvalid[idx] = 1'b1;
         mtag[idx]   = tag;
         mdirty[idx] = 1'b0;
      end
      if (wr) begin
         mmem[widx]  = wdata;
         mdirty[idx] = 1'b1;
      end
      if (hit) mhits = mhits + 32'd1;
      else     mmisses = mmisses + 32'd1;
      t_accept = cycle;
      e.accept = cycle + 1;
      e.due    = cycle + lat;
      e.rdata  = wr ? 32'd0 : mmem[widx];
      e.hit    = hit;
      e.hits   = mhits;
      e.misses = mmisses;
      expq.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (wait_resp) waitResponse();
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      fails++;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      int          first_accept;
      int          resp_before;
      logic [23:0] tags [5];
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      tags[0] = 24'h000000;
      tags[1] = 24'h000001;
      tags[2] = 24'h000002;
      tags[3] = 24'h001000;
      tags[4] = 24'h800000;
      doReset();

      $display("[TB] cold miss then hit");
      applyStimulus(1'b0, 32'h100, 32'd0, 1);
      checkOutput("t1_miss_latency", last_latency, 32'd51);
      checkOutput("t1_miss_rdata", last_rdata, 32'd0);
      checkOutput("t1_miss_hit", {31'd0, last_hit}, 32'd0);
      checkOutput("t1_miss_count", last_misses, 32'd1);
      applyStimulus(1'b0, 32'h100, 32'd0, 1);
      checkOutput("t1_hit_latency", last_latency, 32'd1);
      checkOutput("t1_hit_hit", {31'd0, last_hit}, 32'd1);
      checkOutput("t1_hit_count", last_hits, 32'd1);

      $display("[TB] store hit and neighbouring words");
      applyStimulus(1'b1, 32'h104, 32'hDEADBEEF, 1);
      checkOutput("t2_store_rdata", last_rdata, 32'd0);
      applyStimulus(1'b0, 32'h104, 32'd0, 1);
      checkOutput("t2_load_rdata", last_rdata, 32'hDEADBEEF);
      checkOutput("t2_load_hit", {31'd0, last_hit}, 32'd1);
      applyStimulus(1'b0, 32'h100, 32'd0, 1);
      checkOutput("t2_word0", last_rdata, 32'd0);
      applyStimulus(1'b0, 32'h108, 32'd0, 1);
      checkOutput("t2_word2", last_rdata, 32'd0);
      applyStimulus(1'b0, 32'h10C, 32'd0, 1);
      checkOutput("t2_word3", last_rdata, 32'd0);

      $display("[TB] conflict eviction of a dirty line");
      applyStimulus(1'b0, 32'h504, 32'd0, 1);
      checkOutput("t3_dirty_latency", last_latency, 32'd101);
      checkOutput("t3_dirty_rdata", last_rdata, 32'd0);
      applyStimulus(1'b0, 32'h104, 32'd0, 1);
      checkOutput("t3_reload_latency", last_latency, 32'd51);
      checkOutput("t3_writeback_data", last_rdata, 32'hDEADBEEF);
      checkOutput("t3_reload_hit", {31'd0, last_hit}, 32'd0);

      $display("[TB] back-to-back hits");
      ready_low_seen = 0;
      resp_before = resp_seen;
      first_accept = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 32'h100 + 32'(4 * (i % 4)), 32'd0, 0);
         if (i == 0) first_accept = t_accept;
      end
      @(negedge clk);
      #1;
      checkOutput("t4_ready_never_low", {31'd0, ready_low_seen}, 32'd0);
      checkOutput("t4_accept_span", t_accept - first_accept, 32'd7);
      checkOutput("t4_resp_count", resp_seen - resp_before, 32'd8);
      checkOutput("t4_hit_count", hit_count, 32'd14);
      checkOutput("t4_miss_count", miss_count, 32'd3);

      $display("[TB] reset in the middle of a miss");
      applyStimulus(1'b0, 32'h204, 32'd0, 0);
      repeat (20) @(negedge clk);
      doReset();
      applyStimulus(1'b0, 32'h104, 32'd0, 1);
      checkOutput("t5_data_cleared", last_rdata, 32'd0);
      checkOutput("t5_miss_count", last_misses, 32'd1);
      checkOutput("t5_hit_count", last_hits, 32'd0);

      $display("[TB] requests ignored while busy");
      applyStimulus(1'b0, 32'h300, 32'd0, 0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         req_valid = 1'($urandom_range(0, 1));
         req_write = 1'($urandom_range(0, 1));
         req_addr  = {16'd0, 16'($urandom)} & 32'hFFFF_FFFC;
         req_wdata = $urandom;
      end
      req_valid = 1'b0;
      waitResponse();
      checkOutput("t6_latency", last_latency, 32'd51);
      checkOutput("t6_miss_count", last_misses, 32'd2);
      checkOutput("t6_hit_count", last_hits, 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 150; i++) begin
         logic [31:0] addr;
         addr = {tags[$urandom_range(0, 4)], 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
         applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, bit'($urandom_range(0, 1)));
      end
      begin
         int n;
         n = 0;
         while ((expq.size() > 0) && (n < 400)) begin
            @(negedge clk);
            n++;
         end
         #1;
         checkOutput("drain_outstanding", expq.size(), 32'd0);
      end
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
